// File: rtl/updown_pkg.sv
// Shared constants for the up/down LED counter family: count modes and
// default sizing.
package updown_pkg;
    localparam logic MODE_WRAP        = 1'b0;
    localparam logic MODE_SAT         = 1'b1;
    localparam int   DEFAULT_WIDTH    = 4;
    localparam int   DEFAULT_DIV_BITS = 23;
endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler; TICK is a one-cycle clock enable while the counter
// sits at all-ones. CLR restarts the period from zero.
module tick_prescaler
    import updown_pkg::*;
#(
    parameter int DIV_BITS = DEFAULT_DIV_BITS
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CLR,
    output logic TICK
);

    logic [DIV_BITS-1:0] presc_q;
    logic [DIV_BITS-1:0] presc_d;

    always_comb begin
        presc_d = CLR ? '0 : presc_q + DIV_BITS'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) presc_q <= '0;
        else          presc_q <= presc_d;
    end

    assign TICK = &presc_q;

endmodule

// File: rtl/updown_prescaled_counter.sv
// Up/down counter stepping once per prescaler period, with wrap or saturate
// mode, synchronous load and a registered terminal-count pulse.
module updown_prescaled_counter
    import updown_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DIV_BITS   = DEFAULT_DIV_BITS,
    parameter bit INVERT_OUT = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             UP,
    input  logic             SAT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] COUNT,
    output logic             TICK,
    output logic             TC
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic             tick;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    // LOAD also restarts the prescaler so the next step is a full period away.
    tick_prescaler #(.DIV_BITS(DIV_BITS)) u_presc (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CLR     (LOAD),
        .TICK    (tick)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (LOAD) begin
            count_d = LOAD_VAL;
        end else if (tick && EN) begin
            if (UP) begin
                if (count_q == CNT_MAX) begin
                    tc_d = 1'b1;
                    if (SAT == MODE_WRAP) count_d = '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (SAT == MODE_WRAP) count_d = CNT_MAX;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign COUNT = INVERT_OUT ? ~count_q : count_q;
    assign TICK  = tick;
    assign TC    = tc_q;

endmodule

// File: tb/tb_updown_prescaled_counter.sv
// Bench for updown_prescaled_counter at WIDTH=4, DIV_BITS=2, with true and
// inverted output copies driven in parallel against an arithmetic model.
module tb_updown_prescaled_counter;

    localparam int W    = 4;
    localparam int DIVB = 2;
    localparam int P    = 1 << DIVB;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count, count_inv;
    logic         tick, tick_inv, tc, tc_inv;

    int errors = 0;
    int checks = 0;

    // model state: count value, phase within the prescaler period, TC
    int m_cnt = 0;
    int m_phase = 0;
    int m_tc = 0;

    always #5 clk = ~clk;

    updown_prescaled_counter #(.WIDTH(W), .DIV_BITS(DIVB), .INVERT_OUT(1'b0)) dut (
        .CLK(clk), .RESET_N(rst_n), .EN(en), .UP(up), .SAT(sat), .LOAD(load),
        .LOAD_VAL(load_val), .COUNT(count), .TICK(tick), .TC(tc)
    );

    updown_prescaled_counter #(.WIDTH(W), .DIV_BITS(DIVB), .INVERT_OUT(1'b1)) dut_inv (
        .CLK(clk), .RESET_N(rst_n), .EN(en), .UP(up), .SAT(sat), .LOAD(load),
        .LOAD_VAL(load_val), .COUNT(count_inv), .TICK(tick_inv), .TC(tc_inv)
    );

    // Advance one clock and apply the behavioural rules to the model.
    task automatic step_clk();
        int nxt;
        bit tk;
        @(posedge clk);
        if (rst_n) begin
            tk = (m_phase == P - 1);
            m_tc = 0;
            if (load) begin
                m_cnt = int'(load_val);
                m_phase = 0;
            end else begin
                m_phase = (m_phase + 1) % P;
                if (tk && en) begin
                    nxt = m_cnt + (up ? 1 : -1);
                    if (nxt > MAXV || nxt < 0) begin
                        m_tc = 1;
                        if (!sat) m_cnt = (nxt + MAXV + 1) % (MAXV + 1);
                    end else begin
                        m_cnt = nxt;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        load_val = v;
        step_clk();
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        // power-on: held in reset
        #2;
        checks++;
        if (count_inv !== 4'hF || count !== 4'h0 || tc !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: count_inv=%h count=%h tc=%b tick=%b exp F 0 0 0",
                     count_inv, count, tc, tick);
        end
        step_clk();
        rst_n = 1'b1;
        en = 1'b1; up = 1'b1; sat = 1'b0;
        do_load(4'd5);
        repeat (6) step_clk();
        // mid-period async reset, sampled before any further edge
        rst_n = 1'b0;
        m_cnt = 0; m_phase = 0; m_tc = 0;
        #2;
        checks++;
        if (count_inv !== 4'hF || count !== 4'h0 || tc !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count_inv=%h count=%h tc=%b tick=%b exp F 0 0 0",
                     count_inv, count, tc, tick);
        end
        step_clk();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * P; i++) begin
            step_clk();
            e = m_cnt[W-1:0];
            checks++;
            if (count !== e || tick !== (m_phase == P - 1)) begin
                errors++;
                $display("FAIL reset_release cyc%0d: count=%h tick=%b exp %h %b",
                         i, count, tick, e, (m_phase == P - 1));
            end
        end
    endtask

    task automatic test_wrap_up();
        int tc_seen = 0;
        logic [W-1:0] e;
        en = 1'b1; up = 1'b1; sat = 1'b0;
        do_load(4'd0);
        for (int i = 1; i <= 16 * P; i++) begin
            step_clk();
            e = m_cnt[W-1:0];
            if (tc) tc_seen++;
            checks++;
            if (count !== e || count_inv !== ~e || tc !== m_tc[0]) begin
                errors++;
                $display("FAIL wrap_up cyc%0d: count=%h inv=%h tc=%b exp %h %h %b",
                         i, count, count_inv, tc, e, ~e, m_tc[0]);
            end
        end
        checks++;
        if (count !== 4'd0 || tc !== 1'b1 || tc_seen != 1) begin
            errors++;
            $display("FAIL wrap_up_end: count=%h tc=%b pulses=%0d exp 0 1 1", count, tc, tc_seen);
        end
    endtask

    task automatic test_wrap_down();
        en = 1'b1; up = 1'b0; sat = 1'b0;
        do_load(4'd0);
        repeat (P) step_clk();
        checks++;
        if (count !== 4'd15 || tc !== 1'b1 || m_cnt != 15) begin
            errors++;
            $display("FAIL wrap_down_1: count=%0d tc=%b exp 15 1", count, tc);
        end
        step_clk();
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down_tc_width: tc=%b exp 0", tc);
        end
        repeat (P - 1) step_clk();
        checks++;
        if (count !== 4'd14 || tc !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down_2: count=%0d tc=%b exp 14 0", count, tc);
        end
    endtask

    task automatic test_saturate();
        en = 1'b1; up = 1'b1; sat = 1'b1;
        do_load(4'd14);
        repeat (P) step_clk();
        checks++;
        if (count !== 4'd15 || tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_reach: count=%0d tc=%b exp 15 0", count, tc);
        end
        for (int k = 0; k < 3; k++) begin
            repeat (P) step_clk();
            checks++;
            if (count !== 4'd15 || tc !== 1'b1 || count_inv !== 4'h0) begin
                errors++;
                $display("FAIL sat_hold%0d: count=%0d tc=%b inv=%h exp 15 1 0",
                         k, count, tc, count_inv);
            end
        end
        up = 1'b0;
        repeat (P) step_clk();
        checks++;
        if (count !== 4'd14 || tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_down: count=%0d tc=%b exp 14 0", count, tc);
        end
    endtask

    task automatic test_load_vs_tick();
        int guard = 0;
        int ticks = 0;
        en = 1'b1; up = 1'b1; sat = 1'b0;
        while (m_phase != P - 1 && guard < 2 * P) begin
            step_clk();
            guard++;
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL load_tick_align: tick=%b exp 1 (waited %0d)", tick, guard);
        end
        do_load(4'd9);
        checks++;
        if (count !== 4'd9 || tc !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL load_override: count=%0d tc=%b tick=%b exp 9 0 0", count, tc, tick);
        end
        repeat (P - 1) step_clk();
        checks++;
        if (count !== 4'd9) begin
            errors++;
            $display("FAIL load_early: count=%0d exp 9", count);
        end
        step_clk();
        checks++;
        if (count !== 4'd10) begin
            errors++;
            $display("FAIL load_next_step: count=%0d exp 10", count);
        end
        en = 1'b0;
        for (int i = 0; i < 3 * P; i++) begin
            step_clk();
            if (tick) ticks++;
            checks++;
            if (count !== 4'd10 || tc !== 1'b0) begin
                errors++;
                $display("FAIL en_hold cyc%0d: count=%0d tc=%b exp 10 0", i, count, tc);
            end
        end
        checks++;
        if (ticks != 3) begin
            errors++;
            $display("FAIL en_hold_ticks: ticks=%0d exp 3", ticks);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) != 0;
            sat  = $urandom_range(0, 1) != 0;
            load = ($urandom_range(0, 15) == 0);
            load_val = W'($urandom_range(0, MAXV));
            step_clk();
            e = m_cnt[W-1:0];
            checks++;
            if (count !== e || count_inv !== ~e || tc !== m_tc[0] || tc_inv !== m_tc[0] ||
                tick !== (m_phase == P - 1) || tick_inv !== tick) begin
                errors++;
                $display("FAIL random cyc%0d: count=%h inv=%h tc=%b tick=%b exp %h %h %b %b",
                         i, count, count_inv, tc, tick, e, ~e, m_tc[0], (m_phase == P - 1));
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_vs_tick();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
